amp_i2c_cfg_seq: RTL and testbench

AMP_I2C_CFG_SEQ -- requirements
Module: amp_i2c_cfg_seq

---
 rtl/amp_i2c_cfg_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_amp_i2c_cfg_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_i2c_cfg_seq.sv
// Boot-time amplifier configuration sequencer: walks a small opcode ROM and
// replays it as I2C write transactions with page handling and NACK retries.
module amp_i2c_cfg_seq #(
    parameter int unsigned DIV       = 5,
    parameter int unsigned AW        = 4,
    parameter logic [6:0]  DEV_ADDR  = 7'h20,
    parameter bit          ADDR16    = 1'b0,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          sdai,
    output logic          sdao,
    output logic          scl,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 6;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    localparam logic [1:0] K_DEV  = 2'd0;
    localparam logic [1:0] K_PAGE = 2'd1;
    localparam logic [1:0] K_REG  = 2'd2;
    localparam logic [1:0] K_DATA = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    ph_q, ph_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [1:0]    kind_q, kind_d;
    logic [6:0]    op_q, op_d;
    logic          blk_q, blk_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] op_addr_q, op_addr_d;
    logic [5:0]    page_q, page_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          nack_q, nack_d;
    logic          wrap_q, wrap_d;
    logic          scl_q, scl_d;
    logic          sdao_q, sdao_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    logic          bus_c;
    logic          tick_c;
    logic          load_c;
    logic          inc_pc_c;
    logic [1:0]    kind_nx_c;

    assign bus_c  = (state_q == S_START) || (state_q == S_SHIFT) || (state_q == S_ACK) ||
                    (state_q == S_STOP)  || (state_q == S_GAP);
    assign tick_c = bus_c && (div_q == DW'(DIV - 1));

    // Next-state, byte loading and line levels for the coming cycle
    always_comb begin
        state_d    = state_q;
        div_d      = bus_c ? (tick_c ? '0 : div_q + DW'(1)) : '0;
        ph_d       = ph_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        kind_d     = kind_q;
        op_d       = op_q;
        blk_d      = blk_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        op_addr_d  = op_addr_q;
        page_d     = page_q;
        retry_d    = retry_q;
        nack_d     = nack_q;
        wrap_d     = wrap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        load_c     = 1'b0;
        inc_pc_c   = 1'b0;
        kind_nx_c  = K_DEV;
        scl_d      = 1'b1;
        sdao_d     = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    page_d  = '0;
                    pc_d    = '0;
                    retry_d = '0;
                    wrap_d  = 1'b0;
                end
            end
            S_FETCH: begin
                op_addr_d = pc_q;
                if (wrap_q) begin
                    err_d      = 1'b1;
                    err_addr_d = pc_q;
                    state_d    = S_FINISH;
                end else if (!rom_data[7]) begin
                    op_d     = rom_data[6:0];
                    blk_d    = 1'b0;
                    cnt_d    = CW'(1);
                    inc_pc_c = 1'b1;
                    state_d  = S_START;
                    ph_d     = '0;
                end else if (rom_data[7:6] == 2'b10) begin
                    page_d   = rom_data[5:0];
                    inc_pc_c = 1'b1;
                end else if (rom_data[7:5] == 3'b110) begin
                    blk_d    = 1'b1;
                    cnt_d    = (rom_data[4:0] == 5'd0) ? CW'(32) : CW'(rom_data[4:0]);
                    inc_pc_c = 1'b1;
                    state_d  = S_START;
                    ph_d     = '0;
                end else if (rom_data == 8'hFF) begin
                    state_d = S_FINISH;
                end else begin
                    err_d      = 1'b1;
                    err_addr_d = pc_q;
                    state_d    = S_FINISH;
                end
            end
            S_START: begin
                if (tick_c) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd1) begin
                        state_d   = S_SHIFT;
                        ph_d      = '0;
                        load_c    = 1'b1;
                        kind_nx_c = K_DEV;
                    end
                end
            end
            S_SHIFT: begin
                if (tick_c) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = S_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                            sh_d  = {sh_q[6:0], 1'b0};
                        end
                    end
                end
            end
            S_ACK: begin
                if (tick_c) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd2) begin
                        nack_d = sdai;
                    end
                    if (ph_q == 2'd3) begin
                        if (nack_q) begin
                            state_d = S_STOP;
                            if (retry_q >= RW'(MAX_RETRY)) begin
                                err_d      = 1'b1;
                                err_addr_d = op_addr_q;
                            end
                        end else if ((kind_q == K_DATA) && (cnt_q == CW'(1))) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_SHIFT;
                            load_c  = 1'b1;
                            case (kind_q)
                                K_DEV:   kind_nx_c = ADDR16 ? K_PAGE : K_REG;
                                K_PAGE:  kind_nx_c = K_REG;
                                K_REG:   kind_nx_c = K_DATA;
                                default: begin
                                    kind_nx_c = K_DATA;
                                    cnt_d     = cnt_q - CW'(1);
                                end
                            endcase
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tick_c) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        if (!nack_q) begin
                            retry_d = '0;
                            state_d = S_FETCH;
                        end else if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d = retry_q + RW'(1);
                            pc_d    = op_addr_q;
                            wrap_d  = 1'b0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_FINISH;
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // New byte: device/page/register from registers, register or data from ROM
        if (load_c) begin
            kind_d = kind_nx_c;
            bit_d  = 3'd7;
            case (kind_nx_c)
                K_DEV:  sh_d = {DEV_ADDR, 1'b0};
                K_PAGE: sh_d = {2'b00, page_q};
                K_REG: begin
                    if (blk_q) begin
                        sh_d     = rom_data;
                        inc_pc_c = 1'b1;
                    end else begin
                        sh_d = {1'b0, op_q};
                    end
                end
                default: begin
                    sh_d     = rom_data;
                    inc_pc_c = 1'b1;
                end
            endcase
        end

        if (inc_pc_c) begin
            pc_d = pc_q + AW'(1);
            if (&pc_q) begin
                wrap_d = 1'b1;
            end
        end

        case (state_d)
            S_START: begin
                scl_d  = 1'b1;
                sdao_d = 1'b0;
            end
            S_SHIFT: begin
                scl_d  = ph_d[1];
                sdao_d = sh_d[7];
            end
            S_ACK: begin
                scl_d  = ph_d[1];
                sdao_d = 1'b1;
            end
            S_STOP: begin
                scl_d  = ph_d[1];
                sdao_d = (ph_d == 2'd3);
            end
            default: begin
                scl_d  = 1'b1;
                sdao_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            ph_q       <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            kind_q     <= K_DEV;
            op_q       <= '0;
            blk_q      <= 1'b0;
            cnt_q      <= '0;
            pc_q       <= '0;
            op_addr_q  <= '0;
            page_q     <= '0;
            retry_q    <= '0;
            nack_q     <= 1'b0;
            wrap_q     <= 1'b0;
            scl_q      <= 1'b1;
            sdao_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            kind_q     <= kind_d;
            op_q       <= op_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            op_addr_q  <= op_addr_d;
            page_q     <= page_d;
            retry_q    <= retry_d;
            nack_q     <= nack_d;
            wrap_q     <= wrap_d;
            scl_q      <= scl_d;
            sdao_q     <= sdao_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign rom_addr = pc_q;
    assign scl      = scl_q;
    assign sdao     = sdao_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_amp_i2c_cfg_seq.sv
// Bench for amp_i2c_cfg_seq: a table of ROM programs with expected I2C bytes,
// plus reset, busy-start and mid-transfer reset sequences.
module tb_amp_i2c_cfg_seq;

    localparam int unsigned DIV   = 5;
    localparam int unsigned AW    = 4;
    localparam int          LIMIT = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetb, start0, start1, sdai;
    logic [AW-1:0] ra0, ra1, ea0, ea1;
    logic [7:0]    rd0, rd1;
    logic          sdao0, scl0, busy0, done0, err0;
    logic          sdao1, scl1, busy1, done1, err1;
    logic [7:0]    rom [16];

    assign rd0 = rom[ra0];
    assign rd1 = rom[ra1];

    amp_i2c_cfg_seq #(.DIV(DIV), .AW(AW)) u_dut (
        .clk(clk), .resetb(resetb), .start(start0), .rom_addr(ra0), .rom_data(rd0),
        .sdai(sdai), .sdao(sdao0), .scl(scl0), .busy(busy0), .done(done0),
        .err(err0), .err_addr(ea0)
    );

    amp_i2c_cfg_seq #(.DIV(DIV), .AW(AW), .ADDR16(1'b1)) u_dut16 (
        .clk(clk), .resetb(resetb), .start(start1), .rom_addr(ra1), .rom_data(rd1),
        .sdai(sdai), .sdao(sdao1), .scl(scl1), .busy(busy1), .done(done1),
        .err(err1), .err_addr(ea1)
    );

    logic          sel;
    logic          scl_m, sda_m, done_m, busy_m, err_m;
    logic [AW-1:0] ea_m, ra_m;
    assign scl_m  = sel ? scl1  : scl0;
    assign sda_m  = sel ? sdao1 : sdao0;
    assign done_m = sel ? done1 : done0;
    assign busy_m = sel ? busy1 : busy0;
    assign err_m  = sel ? err1  : err0;
    assign ea_m   = sel ? ea1   : ea0;
    assign ra_m   = sel ? ra1   : ra0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: START/STOP detection and byte capture on SCL rising edges
    logic       mon_clr = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic [7:0] mon_sh;
    int         n_start, n_stop, n_edge, n_done, bidx;
    logic [7:0] bytes [$];
    int         btime [$];

    always @(negedge clk) begin
        if (mon_clr) begin
            n_start = 0; n_stop = 0; n_edge = 0; n_done = 0; bidx = 0; mon_sh = 8'h00;
            bytes.delete();
            btime.delete();
        end else begin
            if (scl_m != p_scl) n_edge++;
            if (p_scl && scl_m && p_sda && !sda_m) begin
                n_start++;
                bidx = 0;
            end
            if (p_scl && scl_m && !p_sda && sda_m) n_stop++;
            if (!p_scl && scl_m) begin
                if (bidx == 0) btime.push_back(cyc);
                if (bidx < 8) mon_sh = {mon_sh[6:0], sda_m};
                bidx++;
                if (bidx == 9) begin
                    bytes.push_back(mon_sh);
                    bidx = 0;
                end
            end
            if (done_m) n_done++;
        end
        p_scl = scl_m;
        p_sda = sda_m;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic        sda;
        logic [63:0] img;
        int          n_img;
        logic [7:0]  fill;
        logic [63:0] exp;
        int          n_exp;
        int          starts;
        int          stops;
        logic        e;
        int          ea;
        int          max_lat;
    } vec_t;

    vec_t v [8];

    task automatic load_rom(input logic [63:0] img, input int n, input logic [7:0] fill);
        logic [63:0] t;
        t = img;
        for (int k = 0; k < 16; k++) begin
            rom[k] = (k < n) ? t[63-8*k -: 8] : fill;
        end
    endtask

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic s);
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input string name, output int k);
        k = 1;
        while (!done_m && k < LIMIT) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done_m) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got busy=%0d exp done", name, busy_m);
        end
    endtask

    task automatic run_vec(input int i, input vec_t t);
        int          lat;
        logic [63:0] e;
        sel  = t.sel;
        sdai = t.sda;
        load_rom(t.img, t.n_img, t.fill);
        clear_mon();
        pulse_start(t.sel);
        chk($sformatf("v%0d_busy_rise", i), int'(busy_m), 1);
        wait_done($sformatf("v%0d", i), lat);
        if (t.max_lat != 0) chk($sformatf("v%0d_latency_ok", i), int'(lat <= t.max_lat), 1);
        chk($sformatf("v%0d_busy_fall", i), int'(busy_m), 0);
        repeat (10) @(posedge clk);
        #1;
        chk($sformatf("v%0d_nbytes", i), bytes.size(), t.n_exp);
        e = t.exp;
        for (int j = 0; j < t.n_exp; j++) begin
            chk($sformatf("v%0d_byte%0d", i, j),
                (j < bytes.size()) ? int'(bytes[j]) : -1, int'(e[63-8*j -: 8]));
        end
        chk($sformatf("v%0d_starts", i), n_start, t.starts);
        chk($sformatf("v%0d_stops", i), n_stop, t.stops);
        chk($sformatf("v%0d_err", i), int'(err_m), int'(t.e));
        if (t.e) chk($sformatf("v%0d_err_addr", i), int'(ea_m), t.ea);
        chk($sformatf("v%0d_done_once", i), n_done, 1);
        if (t.starts == 0) chk($sformatf("v%0d_scl_edges", i), n_edge, 0);
        if (t.n_exp >= 2 && !t.sda)
            chk($sformatf("v%0d_byte_period", i),
                (btime.size() >= 2) ? btime[1] - btime[0] : -1, int'(36 * DIV));
    endtask

    initial begin
        int k;
        v[0] = '{sel:1'b0, sda:1'b0, img:64'h4018_3508_FF00_0000, n_img:5, fill:8'hFF,
                 exp:64'h4040_1840_3508_0000, n_exp:6, starts:2, stops:2, e:1'b0, ea:0, max_lat:0};
        v[1] = '{sel:1'b0, sda:1'b1, img:64'h4018_FF00_0000_0000, n_img:3, fill:8'hFF,
                 exp:64'h4040_4000_0000_0000, n_exp:3, starts:3, stops:3, e:1'b1, ea:0, max_lat:0};
        v[2] = '{sel:1'b0, sda:1'b0, img:64'hC310_AABB_CCFF_0000, n_img:6, fill:8'hFF,
                 exp:64'h4010_AABB_CC00_0000, n_exp:5, starts:1, stops:1, e:1'b0, ea:0, max_lat:0};
        v[3] = '{sel:1'b0, sda:1'b0, img:64'hE000_0000_0000_0000, n_img:1, fill:8'hFF,
                 exp:64'h0, n_exp:0, starts:0, stops:0, e:1'b1, ea:0, max_lat:4};
        v[4] = '{sel:1'b0, sda:1'b0, img:64'h8512_34F0_0000_0000, n_img:4, fill:8'hFF,
                 exp:64'h4012_3400_0000_0000, n_exp:3, starts:1, stops:1, e:1'b1, ea:3, max_lat:0};
        v[5] = '{sel:1'b0, sda:1'b0, img:64'h0, n_img:0, fill:8'h80,
                 exp:64'h0, n_exp:0, starts:0, stops:0, e:1'b1, ea:0, max_lat:0};
        v[6] = '{sel:1'b1, sda:1'b0, img:64'h8502_11FF_0000_0000, n_img:4, fill:8'hFF,
                 exp:64'h4005_0211_0000_0000, n_exp:4, starts:1, stops:1, e:1'b0, ea:0, max_lat:0};
        v[7] = '{sel:1'b1, sda:1'b0, img:64'h0211_FF00_0000_0000, n_img:3, fill:8'hFF,
                 exp:64'h4000_0211_0000_0000, n_exp:4, starts:1, stops:1, e:1'b0, ea:0, max_lat:0};

        sel = 1'b0; start0 = 1'b0; start1 = 1'b0; sdai = 1'b0; resetb = 1'b0;
        load_rom(64'h0, 0, 8'hFF);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_sdao", int'(sdao0), 1);
        chk("rst_scl", int'(scl0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_err_addr", int'(ea0), 0);
        chk("rst_rom_addr", int'(ra0), 0);
        resetb = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(i, v[i]);

        // Start while busy is dropped
        sel = 1'b0; sdai = 1'b0;
        load_rom(64'h4018_FF00_0000_0000, 3, 8'hFF);
        clear_mon();
        pulse_start(1'b0);
        repeat (100) @(posedge clk);
        #1;
        pulse_start(1'b0);
        wait_done("busy_start", k);
        repeat (50) @(posedge clk);
        #1;
        chk("busy_start_starts", n_start, 1);
        chk("busy_start_stops", n_stop, 1);
        chk("busy_start_nbytes", bytes.size(), 3);
        chk("busy_start_done_once", n_done, 1);
        chk("busy_start_idle", int'(busy_m), 0);

        // Reset in the middle of the second byte, then a clean replay
        clear_mon();
        pulse_start(1'b0);
        k = 0;
        while (!(bytes.size() == 1 && bidx == 3 && scl_m == 1'b0) && k < LIMIT) begin
            @(posedge clk); #1;
            k++;
        end
        chk("midrst_reached_byte2", int'(k < LIMIT), 1);
        resetb = 1'b0;
        @(posedge clk); #1;
        chk("midrst_sdao", int'(sdao0), 1);
        chk("midrst_scl", int'(scl0), 1);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_rom_addr", int'(ra0), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_stop", n_stop, 0);
        resetb = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        pulse_start(1'b0);
        wait_done("replay", k);
        repeat (10) @(posedge clk);
        #1;
        chk("replay_nbytes", bytes.size(), 3);
        chk("replay_byte0", (bytes.size() > 0) ? int'(bytes[0]) : -1, 8'h40);
        chk("replay_byte1", (bytes.size() > 1) ? int'(bytes[1]) : -1, 8'h40);
        chk("replay_byte2", (bytes.size() > 2) ? int'(bytes[2]) : -1, 8'h18);
        chk("replay_starts", n_start, 1);
        chk("replay_err", int'(err0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
